// File: rtl/ft_fifo_master.sv
// Half-duplex FT-style USB FIFO bus master: loopback buffer, counting pattern source and pattern sink.
// Define FT_STATS_EN to build the word counters and the sticky sink-mismatch flag.
module ft_fifo_master #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int BURST  = 256
) (
    input  logic                   usb_clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic                   usb_rxf,
    input  logic                   usb_txe,
    output logic                   usb_rd,
    output logic                   usb_wr,
    output logic                   usb_oe,
    input  logic [DATA_W-1:0]      usb_data_in,
    output logic [DATA_W-1:0]      usb_data_out,
    input  logic [DATA_W/8-1:0]    usb_be_in,
    output logic [DATA_W/8-1:0]    usb_be_out,
    output logic                   usb_drive,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [31:0]            stat_rx_cnt,
    output logic [31:0]            stat_tx_cnt,
    output logic                   stat_err
);

    localparam int BE_W = DATA_W / 8;
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int MW   = DATA_W + BE_W;
    localparam int BW   = $clog2(BURST + 1);

    localparam logic [1:0]    MODE_LOOP     = 2'b00;
    localparam logic [1:0]    MODE_SRC      = 2'b01;
    localparam logic [1:0]    MODE_SINK     = 2'b10;
    localparam logic [LW-1:0] LVL_EMPTY     = {LW{1'b0}};
    localparam logic [LW-1:0] LVL_ONE       = LW'(1);
    localparam logic [LW-1:0] LVL_FULL      = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_LAST_FREE = LW'(DEPTH - 1);
    localparam logic [BW-1:0] BURST_LAST    = BW'(BURST - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RX_OE = 3'd1,
        ST_RX    = 3'd2,
        ST_TX    = 3'd3,
        ST_TURN  = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [1:0]        mode_r, cur_mode_s;
    logic              armed_r, last_rd_r;
    logic [BW-1:0]     burst_cnt_r;
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic [MW-1:0]     mem_r [DEPTH];
    logic [MW-1:0]     head_s, head_next_s;
    logic [DATA_W-1:0] pat_r;
    logic [DATA_W-1:0] dout_r, dout_nxt_s;
    logic [BE_W-1:0]   beout_r, beout_nxt_s;
    logic              rd_r, wr_r, oe_r, drive_r;
    logic              full_s, empty_s, rd_elig_s, wr_elig_s;
    logic              accept_s, store_s, consume_s, pop_s;
    logic              burst_last_s, rx_done_s, tx_done_s;

    // Buffer status, bus eligibility and per-edge transfer qualifiers.
    always_comb begin
        full_s  = (level_r == LVL_FULL);
        empty_s = (level_r == LVL_EMPTY);
        if (state_r == ST_IDLE) begin
            cur_mode_s = mode;
        end else begin
            cur_mode_s = mode_r;
        end
        rd_elig_s    = usb_rxf && (((mode == MODE_LOOP) && !full_s) || (mode == MODE_SINK));
        wr_elig_s    = usb_txe && (((mode == MODE_LOOP) && !empty_s) || (mode == MODE_SRC));
        // Sink mode never stores, so it keeps reading regardless of occupancy.
        accept_s     = (state_r == ST_RX) && usb_rxf && ((mode_r == MODE_SINK) || !full_s);
        store_s      = accept_s && (mode_r == MODE_LOOP);
        consume_s    = (state_r == ST_TX) && usb_txe;
        pop_s        = consume_s && (mode_r == MODE_LOOP);
        burst_last_s = (burst_cnt_r == BURST_LAST);
        rx_done_s    = !accept_s || (store_s && (level_r == LVL_LAST_FREE)) || burst_last_s;
        tx_done_s    = !consume_s || (pop_s && (level_r == LVL_ONE)) || burst_last_s;
        head_s       = mem_r[rd_ptr_r];
        head_next_s  = mem_r[rd_ptr_r + AW'(1)];
    end

    // Bus FSM next-state decode with alternating arbitration in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!armed_r) begin
                    state_nxt_s = ST_IDLE;
                end else if (rd_elig_s && wr_elig_s) begin
                    state_nxt_s = last_rd_r ? ST_TX : ST_RX_OE;
                end else if (rd_elig_s) begin
                    state_nxt_s = ST_RX_OE;
                end else if (wr_elig_s) begin
                    state_nxt_s = ST_TX;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RX_OE: state_nxt_s = ST_RX;
            ST_RX: begin
                if (rx_done_s) begin
                    state_nxt_s = ST_TURN;
                end else begin
                    state_nxt_s = ST_RX;
                end
            end
            ST_TX: begin
                if (tx_done_s) begin
                    state_nxt_s = ST_TURN;
                end else begin
                    state_nxt_s = ST_TX;
                end
            end
            ST_TURN: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state, arbitration history, burst counter and strobes registered from the next state.
    always_ff @(posedge usb_clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            mode_r      <= 2'b00;
            armed_r     <= 1'b0;
            last_rd_r   <= 1'b0;
            burst_cnt_r <= {BW{1'b0}};
            rd_r        <= 1'b0;
            wr_r        <= 1'b0;
            oe_r        <= 1'b0;
            drive_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            armed_r <= 1'b1;
            if (state_r == ST_IDLE) begin
                mode_r <= mode;
            end
            if ((state_r == ST_IDLE) && (state_nxt_s == ST_RX_OE)) begin
                last_rd_r <= 1'b1;
            end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_TX)) begin
                last_rd_r <= 1'b0;
            end
            if (accept_s || consume_s) begin
                burst_cnt_r <= burst_cnt_r + BW'(1);
            end else if ((state_r != ST_RX) && (state_r != ST_TX)) begin
                burst_cnt_r <= {BW{1'b0}};
            end
            oe_r    <= (state_nxt_s == ST_RX_OE) || (state_nxt_s == ST_RX);
            rd_r    <= (state_nxt_s == ST_RX);
            wr_r    <= (state_nxt_s == ST_TX);
            drive_r <= (state_nxt_s == ST_TX);
        end
    end

    // Loopback storage array; contents need no reset because the pointers are cleared.
    always_ff @(posedge usb_clk) begin
        if (store_s) begin
            mem_r[wr_ptr_r] <= {usb_be_in, usb_data_in};
        end
    end

    // Buffer pointers and occupancy; store and pop never coincide on a half-duplex bus.
    always_ff @(posedge usb_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= LVL_EMPTY;
        end else begin
            if (store_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
                level_r  <= level_r + LW'(1);
            end else if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                level_r  <= level_r - LW'(1);
            end
        end
    end

    // Next word to present: buffer head (fall-through) or pattern counter.
    always_comb begin
        dout_nxt_s  = dout_r;
        beout_nxt_s = beout_r;
        if (cur_mode_s == MODE_SRC) begin
            beout_nxt_s = {BE_W{1'b1}};
            if (consume_s) begin
                dout_nxt_s = pat_r + DATA_W'(1);
            end else begin
                dout_nxt_s = pat_r;
            end
        end else if (pop_s) begin
            {beout_nxt_s, dout_nxt_s} = head_next_s;
        end else begin
            {beout_nxt_s, dout_nxt_s} = head_s;
        end
    end

    // Pattern counter and registered bus data/byte-enable outputs.
    always_ff @(posedge usb_clk or negedge rst) begin
        if (!rst) begin
            pat_r   <= {DATA_W{1'b0}};
            dout_r  <= {DATA_W{1'b0}};
            beout_r <= {BE_W{1'b0}};
        end else begin
            if (consume_s && (mode_r == MODE_SRC)) begin
                pat_r <= pat_r + DATA_W'(1);
            end
            dout_r  <= dout_nxt_s;
            beout_r <= beout_nxt_s;
        end
    end

`ifdef FT_STATS_EN
    logic [31:0]       rx_cnt_r, tx_cnt_r;
    logic              err_r;
    logic [DATA_W-1:0] exp_r;

    // Word counters and sink sequence checker; a mismatch resynchronises to the received value.
    always_ff @(posedge usb_clk or negedge rst) begin
        if (!rst) begin
            rx_cnt_r <= 32'd0;
            tx_cnt_r <= 32'd0;
            err_r    <= 1'b0;
            exp_r    <= {DATA_W{1'b0}};
        end else begin
            if (accept_s) begin
                rx_cnt_r <= rx_cnt_r + 32'd1;
            end
            if (consume_s) begin
                tx_cnt_r <= tx_cnt_r + 32'd1;
            end
            if (accept_s && (mode_r == MODE_SINK)) begin
                if (usb_data_in != exp_r) begin
                    err_r <= 1'b1;
                    exp_r <= usb_data_in + DATA_W'(1);
                end else begin
                    exp_r <= exp_r + DATA_W'(1);
                end
            end
        end
    end

    assign stat_rx_cnt = rx_cnt_r;
    assign stat_tx_cnt = tx_cnt_r;
    assign stat_err    = err_r;
`else
    assign stat_rx_cnt = 32'd0;
    assign stat_tx_cnt = 32'd0;
    assign stat_err    = 1'b0;
`endif

    assign usb_rd       = rd_r;
    assign usb_wr       = wr_r;
    assign usb_oe       = oe_r;
    assign usb_drive    = drive_r;
    assign usb_data_out = dout_r;
    assign usb_be_out   = beout_r;
    assign fifo_level   = level_r;

endmodule

// File: doc/ft_fifo_master.md
FT_FIFO_MASTER -- requirements
Module: ft_fifo_master

Interface
REQ-001 Parameter DATA_W, 32, USB FIFO bus data width; legal values 16 or 32; BE_W = DATA_W/8.
REQ-002 Parameter DEPTH, 512, loopback buffer depth in words; power of two, at least 8.
REQ-003 Parameter BURST, 256, maximum words per read or write burst; range 1 to DEPTH.
REQ-004 The block SHALL have exactly one clock, usb_clk; reset is rst, asynchronous and active-low.
REQ-005 usb_clk  in  1  FIFO bus clock; all logic is on its rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 mode  in  2  00 loopback, 01 pattern source, 10 pattern sink, 11 idle.
REQ-008 usb_rxf / usb_txe  in  1 each  active-high: device has data / device has space.
REQ-009 usb_rd / usb_wr / usb_oe  out  1 each  active-high strobes, inverted outside the block.
REQ-010 usb_data_in / usb_data_out  in/out  DATA_W  bus data, split for an external tristate.
REQ-011 usb_be_in / usb_be_out  in/out  BE_W  byte enables carried with each word.
REQ-012 usb_drive  out  1  tristate enable for usb_data_out and usb_be_out.
REQ-013 fifo_level  out  $clog2(DEPTH)+1  current buffer occupancy.
REQ-014 stat_rx_cnt / stat_tx_cnt  out  32 each  received and sent word counts.
REQ-015 stat_err  out  1  sticky sink-mode pattern mismatch.

Function
REQ-016 FSM states are IDLE, RX_OE, RX, TX and TURN, and the FSM SHALL sample mode only in IDLE.
REQ-017 Read is eligible when mode is 00 or 10, usb_rxf=1, and the buffer is not full; sink mode ignores fullness.
REQ-018 Write is eligible when usb_txe=1 and either mode=00 with a non-empty buffer or mode=01.
REQ-019 IDLE with both reads and writes eligible: serve the direction not served last; after reset, read goes first.
REQ-020 IDLE to RX_OE for one cycle: usb_oe=1, usb_rd=0, usb_drive=0; then RX: usb_oe=1, usb_rd=1.
REQ-021 A word is accepted on each edge where usb_rd=1 and usb_rxf=1; it is stored with usb_be_in in modes 00, or checked in mode 10.
REQ-022 RX exits to TURN at the edge where usb_rxf=0, the buffer becomes full, or BURST words have been accepted; no word is accepted past full.
REQ-023 TX: usb_wr=1 and usb_drive=1; usb_data_out/usb_be_out hold the buffer head word (first-word fall-through) or the pattern word; a word is consumed on each edge where usb_wr=1 and usb_txe=1.
REQ-024 TX exits to TURN at the edge where usb_txe=0, the buffer becomes empty (mode 00), or BURST words have been consumed.
REQ-025 TURN lasts one cycle with all strobes and usb_drive at 0, then goes to IDLE.
REQ-026 The pattern source sends a DATA_W counter that starts at 0 and increments per consumed word, with be all ones; it wraps at 2^DATA_W.
REQ-027 Sink: the expected value starts at 0; a mismatch sets stat_err and reloads the expected value to received+1; a match gives expected+1.
REQ-028 A simultaneous buffer store and consume is impossible by construction, because the bus is half-duplex.
REQ-029 stat_rx_cnt and stat_tx_cnt increment per accepted or consumed word and wrap at 2^32.

Reset
REQ-030 When rst=0, the block SHALL immediately force usb_rd, usb_wr, usb_oe and usb_drive to 0, the FSM to IDLE, fifo_level to 0, and all counters, stat_err and the pattern/expected values to 0.
REQ-031 Reset mid-burst SHALL discard buffered data; after release, the first bus action is no earlier than the second edge.

Configuration
REQ-032 With FT_STATS_EN defined, stat_rx_cnt, stat_tx_cnt and stat_err SHALL be functional; without it, they are constant 0 and their logic is removed.

Verification
REQ-033 Loopback: mode=00, device offers 5 words 0x11..0x15 and then drops rxf; txe=1 -> one RX_OE cycle, 5 words stored, then after TURN 5 words written in order, fifo_level 5 then 0.
REQ-034 Full: DEPTH=8, BURST=16, rxf held 1, txe=0 -> exactly 8 words accepted, usb_rd drops on the 8th accept edge, fifo_level=8.
REQ-035 Burst limit: BURST=4, 10 words offered, txe=0 -> bursts of 4, 4 and 2 words, each preceded by RX_OE and followed by TURN.
REQ-036 Source: mode=01, txe low after 3 accepts, then high -> writes 0,1,2, TURN, then resumes at 3.
REQ-037 Sink: 0,1,7,8 received -> stat_err set at the third word and stays set; no further error on 8.
REQ-038 Reset: rst=0 in the middle of a TX burst -> usb_wr=0 and usb_drive=0 without waiting for a clock edge; fifo_level=0.
